mipi_hs_lane_serializer: RTL and testbench
==========================================

Name: mipi_hs_lane_serializer

Overview:
- Transmit-side counterpart of the 4-lane LVDS receive path.
- Accepts one byte per lane per transfer.
- Frames each burst with the HS sync byte, then serializes data LSB-first at 2 bits per lane per clock into the 8-bit parallel word feeding the LVDS transmitter megafunction (tx_in).
- Ends each burst with an HS trail.

Parameters:
- LANES, 4, number of data lanes; tx_data width is 2*LANES.
- SYNC_BYTE, 8'hB8, HS sync pattern sent on every lane before data.
- TRAIL_CYCLES, 4, clocks of trail after the last byte; minimum 1.

Ports:
- clk  in  1  serializer clock; also tx_inclock-rate word clock.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data  in  8*LANES  byte for lane k in s_data[8k+7:8k].
- s_last  in  1  qualifies the final word of a burst.
- tx_data  out  2*LANES  to LVDS tx_in; bit k = later bit of lane k, bit LANES+k = earlier bit of lane k.
- hs_active  out  1  high from first sync cycle through last trail cycle.
- underflow  out  1  sticky; set when a burst is starved.
- clr_underflow  in  1  synchronous clear of underflow.

Behaviour:
- Reset (asynchronous, any time, including mid-burst): state=IDLE, phase=0, tx_data=0, hs_active=0, underflow=0, shift registers=0. Outputs change immediately on rst.
- 2-bit phase counter counts 0..3 in SYNC and DATA. One byte occupies 4 clocks. Pair p carries bits 2p (goes to tx_data[LANES+k]) and 2p+1 (goes to tx_data[k]).
- All outputs except s_ready are registered. s_ready = (state==SYNC | state==DATA) & phase==3, driven combinationally from state.
- IDLE: tx_data=0, hs_active=0, s_ready=0. If s_valid, go to SYNC next cycle. The word is not consumed.
- SYNC: shift registers are loaded with SYNC_BYTE on all lanes and emitted over 4 cycles.
  - At phase 3: if s_valid, accept the word, load the shift registers, go to DATA.
  - At phase 3 with s_valid low: this cannot occur from IDLE entry; if it does, treat it as an underflow (below).
- DATA: emit the current byte.
  - At phase 3 with s_last recorded for the current byte: go to TRAIL. s_ready is still high, but a word arriving in that cycle belongs to the next burst: suppress s_ready when the recorded last flag is set.
  - At phase 3 otherwise, with s_valid: accept the next word back-to-back, with no gap on tx_data.
  - At phase 3 otherwise, with s_valid low: set underflow, go to TRAIL.
- TRAIL: each lane drives the complement of its last transmitted bit on both bit positions for TRAIL_CYCLES clocks, then returns to IDLE. tx_data is 0 from the next cycle.
- Latency: s_valid seen in IDLE at cycle N. Sync pairs appear at N+1..N+4, s_ready is high at N+4, and the first data pair appears at N+5.
- Steady state is one word accepted every 4 clocks.
- underflow: if set and clr_underflow happen in the same cycle, set wins.

Optional Feature:
- MIPI_TX_STATS_EN defined: adds output word_cnt [15:0].
  - Cleared on entry to SYNC.
  - Increments on every accepted word and saturates at 16'hFFFF.
  - Holds its value through TRAIL and IDLE.
  - Resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mipi_tx_pkg:
  - state enum {IDLE, SYNC, DATA, TRAIL}.
  - HS_SYNC constant 8'hB8.
  - BITS_PER_CLK=2.
  - Function mapping a per-lane 2-bit pair to tx_data bit positions.
- Sub-module mipi_tx_lane_shift:
  - Per-lane 8-bit load/shift register.
  - Emits 2 bits/clock LSB-first and retains its last bit for trail.
  - Instantiated LANES times.

Test Plan:
- Sync framing: raise s_valid with s_data=32'h0, s_last=1 from IDLE -> tx_data 8'h00, 8'h0F, 8'hFF, 8'h0F at N+1..N+4; hs_active rises at N+1.
- Single word: s_data=32'hB8B8B8B8 after sync -> data pairs 00,0F,FF,0F; then 4 trail cycles of 8'h00 (complement of last bit 1 on each lane); then IDLE with tx_data=0.
- Back-to-back: 3 words, lane0 bytes 8'h01, 8'h80, 8'hFF, others 0, s_valid held high, s_last on the third -> s_ready pulses every 4 clocks with no gap; lane0 bits decode back to 01,80,FF; underflow=0.
- Underflow: drop s_valid before the second word without s_last -> underflow=1, TRAIL entered; clr_underflow pulse clears it.
- Async reset mid-DATA: assert rst at phase 2 -> tx_data=0 and hs_active=0 immediately; a new burst after release starts cleanly with sync.
- Stats (MIPI_TX_STATS_EN): 5-word burst -> word_cnt=5 after TRAIL; next burst clears it at SYNC.

Source files
------------

// File: rtl/mipi_tx_pkg.sv
// Shared types and constants for the MIPI HS transmit serializer.
package mipi_tx_pkg;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, TRAIL} state_t;

    localparam logic [7:0] HS_SYNC      = 8'hB8;
    localparam int         BITS_PER_CLK = 2;

    // Earlier bit of a lane's pair sits in the upper half of tx_data, later bit in the lower half.
    function automatic int tx_bit_pos(input int lane, input int lanes, input logic early);
        return early ? (lanes + lane) : lane;
    endfunction

endpackage

// File: rtl/mipi_tx_lane_shift.sv
// One lane's byte shifter: emits 2 bits per clock LSB-first and remembers the
// last transmitted bit so the trail can drive its complement.
module mipi_tx_lane_shift
    import mipi_tx_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_shift,
    input  logic                    i_trail,
    input  logic [7:0]              i_byte,
    output logic [BITS_PER_CLK-1:0] o_pair
);

    logic [7:0]              r_shift;
    logic [BITS_PER_CLK-1:0] r_pair;
    logic                    r_last_bit;

    // The loaded byte's first pair goes straight out; the rest waits in r_shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_pair     <= '0;
            r_last_bit <= 1'b0;
        end else if (i_load) begin
            r_pair     <= i_byte[1:0];
            r_shift    <= {2'b00, i_byte[7:2]};
            r_last_bit <= i_byte[1];
        end else if (i_shift) begin
            r_pair     <= r_shift[1:0];
            r_shift    <= {2'b00, r_shift[7:2]};
            r_last_bit <= r_shift[1];
        end else if (i_trail) begin
            r_pair     <= {2{~r_last_bit}};
        end else begin
            r_pair     <= '0;
            r_shift    <= '0;
        end
    end

    assign o_pair = r_pair;

endmodule

// File: rtl/mipi_hs_lane_serializer.sv
// HS burst framer/serializer: sync byte, LSB-first data at 2 bits/lane/clock, trail.
// Optional MIPI_TX_STATS_EN adds a saturating per-burst accepted-word counter (word_cnt).
module mipi_hs_lane_serializer
    import mipi_tx_pkg::*;
#(
    parameter int         LANES        = 4,
    parameter logic [7:0] SYNC_BYTE    = HS_SYNC,
    parameter int         TRAIL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [8*LANES-1:0]   s_data,
    input  logic                 s_last,
    output logic [2*LANES-1:0]   tx_data,
    output logic                 hs_active,
    output logic                 underflow,
    input  logic                 clr_underflow
`ifdef MIPI_TX_STATS_EN
    ,
    output logic [15:0]          word_cnt
`endif
);

    localparam int             TW         = (TRAIL_CYCLES > 1) ? $clog2(TRAIL_CYCLES) : 1;
    localparam logic [TW-1:0]  TRAIL_LAST = TW'(TRAIL_CYCLES - 1);

    state_t                          r_state;
    logic [1:0]                      r_phase;
    logic                            r_last;
    logic [TW-1:0]                   r_trail_cnt;
    logic                            r_hs_active;
    logic                            r_underflow;

    logic                            w_phase_end, w_ready, w_accept, w_starve;
    logic                            w_start, w_load, w_shift, w_trail;
    logic [LANES-1:0][BITS_PER_CLK-1:0] w_pair;
    logic [2*LANES-1:0]              w_tx;

    assign w_phase_end = (r_phase == 2'd3);
    // A recorded last flag closes the burst, so a word offered then belongs to the next one.
    assign w_ready  = ((r_state == SYNC) | ((r_state == DATA) & ~r_last)) & w_phase_end;
    assign w_accept = s_valid & w_ready;
    assign w_starve = w_ready & ~s_valid;
    assign w_start  = (r_state == IDLE) & s_valid;
    assign w_load   = w_start | w_accept;
    assign w_shift  = ((r_state == SYNC) | (r_state == DATA)) & ~w_phase_end;
    assign w_trail  = (((r_state == SYNC) | (r_state == DATA)) & w_phase_end & ~w_accept) |
                      ((r_state == TRAIL) & (r_trail_cnt != TRAIL_LAST));
    assign s_ready  = w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase     <= 2'd0;
            r_last      <= 1'b0;
            r_trail_cnt <= '0;
            r_hs_active <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_state     <= SYNC;
                        r_phase     <= 2'd0;
                        r_last      <= 1'b0;
                        r_hs_active <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    r_phase <= r_phase + 2'd1;
                    if (w_phase_end) begin
                        if (w_accept) begin
                            r_state <= DATA;
                            r_last  <= s_last;
                        end else begin
                            r_state     <= TRAIL;
                            r_trail_cnt <= '0;
                        end
                    end
                end
                TRAIL: begin
                    if (r_trail_cnt == TRAIL_LAST) begin
                        r_state     <= IDLE;
                        r_hs_active <= 1'b0;
                    end else begin
                        r_trail_cnt <= r_trail_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_starve)
                r_underflow <= 1'b1;
            else if (clr_underflow)
                r_underflow <= 1'b0;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mipi_tx_lane_shift u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load),
            .i_shift (w_shift),
            .i_trail (w_trail),
            .i_byte  (w_start ? SYNC_BYTE : s_data[8*k +: 8]),
            .o_pair  (w_pair[k])
        );
    end

    always_comb begin
        w_tx = '0;
        for (int k = 0; k < LANES; k++) begin
            w_tx[tx_bit_pos(k, LANES, 1'b1)] = w_pair[k][0];
            w_tx[tx_bit_pos(k, LANES, 1'b0)] = w_pair[k][1];
        end
    end

    assign tx_data   = w_tx;
    assign hs_active = r_hs_active;
    assign underflow = r_underflow;

`ifdef MIPI_TX_STATS_EN
    logic [15:0] r_word_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_word_cnt <= '0;
        else if (w_start)
            r_word_cnt <= '0;
        else if (w_accept && (r_word_cnt != 16'hFFFF))
            r_word_cnt <= r_word_cnt + 16'd1;
    end

    assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_mipi_hs_lane_serializer.sv
// Directed bench for mipi_hs_lane_serializer (4 lanes, sync 8'hB8, 4 trail clocks).
module tb_mipi_hs_lane_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [7:0]  tx_data;
    logic        hs_active;
    logic        underflow;
    logic        clr_underflow = 1'b0;
`ifdef MIPI_TX_STATS_EN
    logic [15:0] word_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_sync [4];

    mipi_hs_lane_serializer dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .tx_data       (tx_data),
        .hs_active     (hs_active),
        .underflow     (underflow),
        .clr_underflow (clr_underflow)
`ifdef MIPI_TX_STATS_EN
        ,
        .word_cnt      (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx actual=%h expected=00", tx_data); else n_pass++;
        n_checks++; if (hs_active !== 1'b0) $display("FAIL reset_hs actual=%b expected=0", hs_active); else n_pass++;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL reset_ready actual=%b expected=0", s_ready); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL reset_uf actual=%b expected=0", underflow); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        tick;
    endtask

    // Zero word with s_last: sync pattern, zero data, trail of all ones.
    task automatic test_sync_framing;
        s_valid = 1'b1; s_data = 32'h0; s_last = 1'b1;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL idle_ready actual=%b expected=0", s_ready); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++; if (tx_data !== exp_sync[i]) $display("FAIL sync_tx%0d actual=%h expected=%h", i, tx_data, exp_sync[i]); else n_pass++;
            n_checks++; if (hs_active !== 1'b1) $display("FAIL sync_hs%0d actual=%b expected=1", i, hs_active); else n_pass++;
            n_checks++; if (s_ready !== (i == 3)) $display("FAIL sync_ready%0d actual=%b expected=%b", i, s_ready, (i == 3)); else n_pass++;
        end
        tick; s_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (p > 0) tick;
            n_checks++; if (tx_data !== 8'h00) $display("FAIL zero_data%0d actual=%h expected=00", p, tx_data); else n_pass++;
        end
        for (int t = 0; t < 4; t++) begin
            tick;
            n_checks++; if (tx_data !== 8'hFF) $display("FAIL zero_trail%0d actual=%h expected=FF", t, tx_data); else n_pass++;
        end
        tick;
        n_checks++; if (tx_data !== 8'h00 || hs_active !== 1'b0) $display("FAIL zero_idle actual=%h/%b expected=00/0", tx_data, hs_active); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL zero_uf actual=%b expected=0", underflow); else n_pass++;
    endtask

    task automatic test_single_word;
        s_valid = 1'b1; s_data = 32'hB8B8B8B8; s_last = 1'b1;
        repeat (4) tick;
        tick; s_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (p > 0) tick;
            n_checks++; if (tx_data !== exp_sync[p]) $display("FAIL word_data%0d actual=%h expected=%h", p, tx_data, exp_sync[p]); else n_pass++;
        end
        n_checks++; if (s_ready !== 1'b0) $display("FAIL word_last_ready actual=%b expected=0", s_ready); else n_pass++;
        for (int t = 0; t < 4; t++) begin
            tick;
            n_checks++; if (tx_data !== 8'h00 || hs_active !== 1'b1) $display("FAIL word_trail%0d actual=%h/%b expected=00/1", t, tx_data, hs_active); else n_pass++;
        end
        tick;
        n_checks++; if (tx_data !== 8'h00 || hs_active !== 1'b0) $display("FAIL word_idle actual=%h/%b expected=00/0", tx_data, hs_active); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [3];
        logic [7:0] got;
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        s_valid = 1'b1; s_data = {24'h0, words[0]}; s_last = 1'b0;
        repeat (4) tick;
        for (int w = 0; w < 3; w++) begin
            got = '0;
            for (int p = 0; p < 4; p++) begin
                tick;
                if (p == 0) begin
                    if (w < 2) begin
                        s_data = {24'h0, words[w+1]};
                        s_last = (w == 1);
                    end else begin
                        s_valid = 1'b0; s_last = 1'b0;
                    end
                end
                got[2*p]   = tx_data[4];
                got[2*p+1] = tx_data[0];
                n_checks++; if (s_ready !== (p == 3 && w < 2)) $display("FAIL b2b_ready w%0d p%0d actual=%b expected=%b", w, p, s_ready, (p == 3 && w < 2)); else n_pass++;
            end
            n_checks++; if (got !== words[w]) $display("FAIL b2b_byte%0d actual=%h expected=%h", w, got, words[w]); else n_pass++;
        end
        tick;
        n_checks++; if (tx_data !== 8'hEE) $display("FAIL b2b_trail actual=%h expected=EE", tx_data); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("FAIL b2b_uf actual=%b expected=0", underflow); else n_pass++;
        repeat (3) tick;
        tick;
        n_checks++; if (hs_active !== 1'b0 || tx_data !== 8'h00) $display("FAIL b2b_idle actual=%h/%b expected=00/0", tx_data, hs_active); else n_pass++;
    endtask

    task automatic test_underflow;
        s_valid = 1'b1; s_data = 32'hB8B8B8B8; s_last = 1'b0;
        repeat (4) tick;
        tick; s_valid = 1'b0;
        repeat (3) tick;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL uf_ready actual=%b expected=1", s_ready); else n_pass++;
        tick;
        n_checks++; if (underflow !== 1'b1) $display("FAIL uf_set actual=%b expected=1", underflow); else n_pass++;
        n_checks++; if (tx_data !== 8'h00 || hs_active !== 1'b1) $display("FAIL uf_trail actual=%h/%b expected=00/1", tx_data, hs_active); else n_pass++;
        repeat (3) tick;
        tick;
        n_checks++; if (hs_active !== 1'b0 || underflow !== 1'b1) $display("FAIL uf_idle actual=%b/%b expected=0/1", hs_active, underflow); else n_pass++;
        clr_underflow = 1'b1;
        tick;
        clr_underflow = 1'b0;
        n_checks++; if (underflow !== 1'b0) $display("FAIL uf_clear actual=%b expected=0", underflow); else n_pass++;
    endtask

    task automatic test_async_reset;
        s_valid = 1'b1; s_data = 32'hFFFFFFFF; s_last = 1'b1;
        repeat (4) tick;
        tick; s_valid = 1'b0;
        repeat (2) tick;
        n_checks++; if (tx_data !== 8'hFF) $display("FAIL rst_pre actual=%h expected=FF", tx_data); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (tx_data !== 8'h00 || hs_active !== 1'b0) $display("FAIL rst_async actual=%h/%b expected=00/0", tx_data, hs_active); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        tick;
        s_valid = 1'b1; s_data = 32'h0; s_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++; if (tx_data !== exp_sync[i] || hs_active !== 1'b1) $display("FAIL rst_resync%0d actual=%h/%b expected=%h/1", i, tx_data, hs_active, exp_sync[i]); else n_pass++;
        end
        tick; s_valid = 1'b0;
        repeat (3 + 4) tick;
        tick;
        n_checks++; if (tx_data !== 8'h00 || hs_active !== 1'b0) $display("FAIL rst_idle actual=%h/%b expected=00/0", tx_data, hs_active); else n_pass++;
    endtask

`ifdef MIPI_TX_STATS_EN
    task automatic test_stats;
        s_valid = 1'b1; s_data = 32'h12345678; s_last = 1'b0;
        repeat (4) tick;
        for (int w = 0; w < 5; w++) begin
            tick;
            if (w == 3) s_last = 1'b1;
            if (w == 4) begin s_valid = 1'b0; s_last = 1'b0; end
            repeat (3) tick;
        end
        repeat (4) tick;
        n_checks++; if (word_cnt !== 16'd5) $display("FAIL stats_trail actual=%0d expected=5", word_cnt); else n_pass++;
        tick;
        n_checks++; if (word_cnt !== 16'd5 || hs_active !== 1'b0) $display("FAIL stats_idle actual=%0d/%b expected=5/0", word_cnt, hs_active); else n_pass++;
        s_valid = 1'b1; s_last = 1'b1;
        tick;
        n_checks++; if (word_cnt !== 16'd0) $display("FAIL stats_clear actual=%0d expected=0", word_cnt); else n_pass++;
        repeat (3) tick;
        tick; s_valid = 1'b0; s_last = 1'b0;
        repeat (3 + 4) tick;
        tick;
        n_checks++; if (word_cnt !== 16'd1) $display("FAIL stats_one actual=%0d expected=1", word_cnt); else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_sync[0] = 8'h00; exp_sync[1] = 8'h0F; exp_sync[2] = 8'hFF; exp_sync[3] = 8'h0F;
        test_reset;
        test_sync_framing;
        test_single_word;
        test_back_to_back;
        test_underflow;
        test_async_reset;
`ifdef MIPI_TX_STATS_EN
        test_stats;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
